// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin arbiter family.
package arb_pkg;

  localparam int unsigned N_PORTS = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DATA_W  = 32;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux4_w32.sv
// Library 32-bit 4:1 word mux.
module mux4_w32 (
  input  logic [1:0]  sel_i,
  input  logic [31:0] in0_i,
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  input  logic [31:0] in3_i,
  output logic [31:0] out_o
);

  // Select one of four words.
  always_comb begin
    out_o = in0_i;
    unique case (sel_i)
      2'd0:    out_o = in0_i;
      2'd1:    out_o = in1_i;
      2'd2:    out_o = in2_i;
      default: out_o = in3_i;
    endcase
  end

endmodule

// File: rtl/rr_prio_enc4.sv
// Rotating-priority encoder: first requester at or after ptr wins.
module rr_prio_enc4
  import arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req_i,
  input  sel_t               ptr_i,
  output sel_t               grant_o,
  output logic               any_o
);

  // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); grant is 0 when nothing requests.
  always_comb begin
    sel_t idx;
    grant_o = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = ptr_i + sel_t'(i);
      if (!any_o && req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_stage.sv
// 4-input round-robin arbiter feeding a one-entry registered output buffer.
module rr_arb4_stage
  import arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS-1:0]    recv_val,
  input  logic [DATA_W-1:0]     recv_msg0,
  input  logic [DATA_W-1:0]     recv_msg1,
  input  logic [DATA_W-1:0]     recv_msg2,
  input  logic [DATA_W-1:0]     recv_msg3,
  output logic [N_PORTS-1:0]    recv_rdy,
  output logic                  send_val,
  output logic [DATA_W-1:0]     send_msg,
  output logic [SEL_W-1:0]      send_src,
  input  logic                  send_rdy,
  output logic [SEL_W-1:0]      grant_se
);

  sel_t              ptr_q, ptr_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  sel_t              src_q, src_d;

  sel_t              grant;
  logic              any_val;
  logic [DATA_W-1:0] mux_out;
  logic              can_accept;
  logic              accept;
  logic              drain;

  rr_prio_enc4 u_enc (
    .req_i   (recv_val),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .any_o   (any_val)
  );

  mux4_w32 u_mux (
    .sel_i (grant),
    .in0_i (recv_msg0),
    .in1_i (recv_msg1),
    .in2_i (recv_msg2),
    .in3_i (recv_msg3),
    .out_o (mux_out)
  );

  // Handshake decode; a draining slot may be refilled in the same cycle.
  always_comb begin
    can_accept = !full_q || send_rdy;
    // Gating with reset keeps recv_rdy low for the whole reset assertion.
    accept     = any_val && can_accept && reset;
    drain      = full_q && send_rdy;
    recv_rdy   = accept ? (4'b0001 << grant) : 4'b0000;
    grant_se   = grant;
  end

  // Next-state: load on accept, clear on drain-only, pointer moves only on transfer.
  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    data_d = data_q;
    src_d  = src_q;
    if (accept) begin
      data_d = mux_out;
      src_d  = grant;
      full_d = 1'b1;
      ptr_d  = grant + sel_t'(1);
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign send_val = full_q;
  assign send_msg = data_q;
  assign send_src = src_q;

endmodule

// File: doc/rr_arb4_stage.md
# rr_arb4_stage

4-input round-robin arbiter stage that merges four 32-bit val/rdy request streams into one registered output stream. It generates the 2-bit select for the library 32-bit 4:1 word mux, which it instantiates for the data path, and holds the winning word in a one-entry output buffer. It sits directly upstream of any single-consumer stage that needs fair access from four producers.

## Interface
- No parameters. Data width is fixed at 32 to match the library 4:1 mux; the port count is fixed at 4.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- recv_val  input  4  per-port request valid; bit i belongs to port i.
- recv_msg0..recv_msg3  input  32 each  per-port request data.
- recv_rdy  output  4  per-port ready, one-hot or zero.
- send_val  output  1  output buffer holds a valid word.
- send_msg  output  32  buffered word.
- send_src  output  2  index of the port that supplied send_msg.
- send_rdy  input  1  downstream accepts the word.
- grant_se  output  2  current combinational grant; drives the mux select. Value is 0 when nothing is granted.

## Operation
- State: priority pointer ptr (2 b), buffer full flag, data register (32 b), source register (2 b).
- Grant: scan ports ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first port with recv_val=1 wins, giving grant_se and any_val.
- can_accept = !full || send_rdy. A word being drained this cycle frees the slot in the same cycle.
- recv_rdy[grant_se] = can_accept && any_val. All other recv_rdy bits are 0.
- recv_rdy is 0 on every bit while reset is asserted.
- Accept (recv_val[g] && recv_rdy[g]):
  - data ← mux output; src ← g; full ← 1; ptr ← (g+1) mod 4.
- Drain without accept (send_val && send_rdy, no accept): full ← 0. Data and src hold.
- Simultaneous drain and accept: buffer reloads, full stays 1, and there is no bubble.
- No accept: ptr holds. The pointer advances only on an actual transfer, never on a mere request.
- The grant does not depend on send_rdy; only recv_rdy is gated.
- Once a requester's recv_val is high it is served within 4 accepts (starvation bound).
- Reset (asynchronous, any time, including mid-transfer): ptr=0, full=0, send_val=0, send_msg=0, send_src=0. Any in-flight word is discarded.

## Timing
- Latency: a word accepted in cycle N appears on send_val/send_msg/send_src in cycle N+1.
- Throughput: 1 word/cycle when send_rdy is held high.
- send_val, send_msg, and send_src are driven directly from registers.
- recv_rdy and grant_se are combinational from recv_val, ptr, full, and send_rdy.
- Buffer full with send_rdy=0: all recv_rdy bits are 0, and send_msg/send_src stay stable until the handshake.
- ptr wraps from 3 to 0.
- A single requester on port k is granted every cycle regardless of ptr.
- Release of reset is synchronized by the integrator; the block does not re-time it.

## Structure
- Shared package arb_pkg holds:
  - localparams N_PORTS=4, SEL_W=2, DATA_W=32.
  - typedef sel_t (logic [1:0]).
- Sub-module rr_prio_enc4: purely combinational. It takes (req[3:0], ptr) and produces (grant, any). It is reused by the later multi-port arbiters.
- The data path is one instance of the library 32-bit 4:1 mux, with select = grant_se. There is no separate data mux in this block.

## Test plan
- Reset then idle, recv_val=0000: send_val=0, send_msg=0, send_src=0, recv_rdy=0000, grant_se=0.
- Port 2 alone, msg 0xDEADBEEF, send_rdy=1: recv_rdy=0100. The next cycle gives send_val=1, send_msg=0xDEADBEEF, send_src=2, and ptr=3.
- All four valid continuously with send_rdy=1 from ptr=0: grant sequence 0,1,2,3,0. send_src follows one cycle later with no bubbles.
- Backpressure: buffer full and send_rdy=0 for 3 cycles with all ports valid. recv_rdy=0000, send_msg is held, and ptr is unchanged. Raising send_rdy then gives a same-cycle drain and accept of the next port.
- Ports 1 and 3 valid, ptr=2: port 3 is granted, ptr becomes 0, and port 1 is granted next.
- Reset asserted mid-stream with the buffer full: outputs clear asynchronously, before the next clk edge. After release, the first grant starts from port 0.
